i2s_tx_stereo16: RTL

I2S_TX_STEREO16 -- requirements
Module: i2s_tx_stereo16

---
 rtl/i2s_tx_stereo16.sv | 129 ++++++++++++
 1 files changed

// File: rtl/i2s_tx_stereo16.sv
// I2S stereo 16-bit transmitter: one-pair holding buffer, realigns on every lrck edge,
// sends each sample MSB first one bck after the lrck change and pads the 32-bit slot with zeros.
module i2s_tx_stereo16 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bck,
    input  logic        lrck,
    input  logic [15:0] din_left,
    input  logic [15:0] din_right,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        sdata,
    output logic        underrun,
    output logic        sync_error,
    output logic        active
);

    typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    state_t      state, state_d;
    logic [2:0]  bck_sync;
    logic [1:0]  lrck_sync;
    logic        lrck_s, lrck_r;
    logic        bck_rise, bck_fall;
    logic        boundary, left_bnd;
    logic        accept;
    pair_t       hold;
    logic        full;
    pair_t       cur;
    logic [15:0] word;
    logic [4:0]  bit_cnt;
    logic [5:0]  rise_cnt;

    // Two flops for metastability, the third only for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
        end else begin
            bck_sync  <= {bck_sync[1:0], bck};
            lrck_sync <= {lrck_sync[0], lrck};
        end
    end

    assign bck_rise = bck_sync[1] & ~bck_sync[2];
    assign bck_fall = ~bck_sync[1] & bck_sync[2];
    assign lrck_s   = lrck_sync[1];
    assign boundary = bck_rise && (lrck_s != lrck_r);
    assign left_bnd = boundary && !lrck_s;
    assign accept   = din_valid && din_ready;
    assign active   = (state != ALIGN);
    assign word     = (state == RIGHT) ? cur.r : cur.l;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ALIGN;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (boundary) begin
            case (state)
                ALIGN:   if (!lrck_s) state_d = LEFT;
                default: state_d = lrck_s ? RIGHT : LEFT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lrck_r <= 1'b0;
        else if (bck_rise) lrck_r <= lrck_s;
    end

    // An accept colliding with an empty-buffer load is kept for the next frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold      <= '0;
            full      <= 1'b0;
            din_ready <= 1'b0;
            cur       <= '0;
            underrun  <= 1'b0;
        end else begin
            if (accept) begin
                hold <= '{l: din_left, r: din_right};
                full <= 1'b1;
            end else if (left_bnd) begin
                full <= 1'b0;
            end
            din_ready <= !(accept || (full && !left_bnd));
            if (left_bnd)
                cur <= full ? hold : '0;
            underrun <= left_bnd && !full;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt <= '0;
            sdata   <= 1'b0;
        end else begin
            if (boundary)
                bit_cnt <= '0;
            else if (bck_fall && state != ALIGN && bit_cnt != 5'd31)
                bit_cnt <= bit_cnt + 5'd1;
            // 15 - bit_cnt on four bits is the bitwise inverse.
            if (state == ALIGN)
                sdata <= 1'b0;
            else if (bck_fall)
                sdata <= bit_cnt[4] ? 1'b0 : word[~bit_cnt[3:0]];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise_cnt   <= '0;
            sync_error <= 1'b0;
        end else begin
            if (bck_rise)
                rise_cnt <= boundary ? 6'd0 : (rise_cnt == 6'd63 ? 6'd63 : rise_cnt + 6'd1);
            sync_error <= boundary && state != ALIGN && rise_cnt != 6'd31;
        end
    end

endmodule
